// File: rtl/mem_access_controller.sv
// MEM-stage load/store controller: one req/ack data-memory transaction per
// instruction, with byte-lane steering, load extension, stall and error pulses.
module mem_access_controller #(
   parameter int TIMEOUT_CYCLES = 16,
   parameter int CNT_W          = 5
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [2:0]  mem_load_type,
   input  logic [1:0]  mem_store_type,
   input  logic [31:0] addr,
   input  logic [31:0] store_data,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [3:0]  dmem_wstrb,
   output logic [31:0] dmem_wdata,
   input  logic        dmem_ack,
   input  logic [31:0] dmem_rdata,
   output logic        stall,
   output logic        load_valid,
   output logic [31:0] load_data,
   output logic        misaligned,
   output logic        bus_err
);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   localparam logic [2:0] LB = 3'd0, LH = 3'd1, LW = 3'd2, LBU = 3'd3, LHU = 3'd4;
   localparam logic [1:0] SB = 2'd0, SH = 2'd1, SW = 2'd2;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [31:0]      addr_q, wdata_q;
   logic [3:0]       wstrb_q;
   logic             we_q;
   logic [2:0]       ltype_q;
   logic [1:0]       off_q;

   logic        op, illegal, mis;
   logic [3:0]  wstrb_c;
   logic [31:0] wdata_c;

   assign op = mem_read | mem_write;

   assign illegal = (mem_read & mem_write)
                  | (mem_read  & (mem_load_type > LHU))
                  | (mem_write & (mem_store_type == 2'd3));

   assign mis = (mem_read  & (((mem_load_type == LH) | (mem_load_type == LHU)) & addr[0]))
              | (mem_read  & ((mem_load_type == LW) & (addr[1:0] != 2'b00)))
              | (mem_write & ((mem_store_type == SH) & addr[0]))
              | (mem_write & ((mem_store_type == SW) & (addr[1:0] != 2'b00)));

   always_comb begin
      wstrb_c = 4'b0000;
      wdata_c = 32'h0;
      if (mem_write) begin
         case (mem_store_type)
            SB: begin wstrb_c = 4'b0001 << addr[1:0]; wdata_c = {4{store_data[7:0]}};  end
            SH: begin wstrb_c = 4'b0011 << addr[1:0]; wdata_c = {2{store_data[15:0]}}; end
            SW: begin wstrb_c = 4'b1111;              wdata_c = store_data;            end
            default: ;
         endcase
      end
   end

   function automatic logic [31:0] extract(input logic [31:0] rd, input logic [2:0] lt,
                                           input logic [1:0] off);
      logic [31:0] s;
      s = rd >> {off, 3'b000};
      case (lt)
         LB:      extract = {{24{s[7]}}, s[7:0]};
         LH:      extract = {{16{s[15]}}, s[15:0]};
         LBU:     extract = {24'h0, s[7:0]};
         LHU:     extract = {16'h0, s[15:0]};
         default: extract = s;
      endcase
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         cnt        <= '0;
         addr_q     <= 32'h0;
         wdata_q    <= 32'h0;
         wstrb_q    <= 4'b0000;
         we_q       <= 1'b0;
         ltype_q    <= 3'd0;
         off_q      <= 2'd0;
         load_valid <= 1'b0;
         load_data  <= 32'h0;
         misaligned <= 1'b0;
         bus_err    <= 1'b0;
      end else begin
         load_valid <= 1'b0;
         misaligned <= 1'b0;
         bus_err    <= 1'b0;
         case (state)
            IDLE: if (op) begin
               if (mis) begin
                  misaligned <= 1'b1;
                  state      <= DONE;
               end else if (illegal) begin
                  bus_err <= 1'b1;
                  state   <= DONE;
               end else begin
                  addr_q  <= {addr[31:2], 2'b00};
                  off_q   <= addr[1:0];
                  wdata_q <= wdata_c;
                  wstrb_q <= wstrb_c;
                  we_q    <= mem_write;
                  ltype_q <= mem_load_type;
                  cnt     <= '0;
                  state   <= BUSY;
               end
            end
            // An ack on the final timeout cycle still wins over the timeout.
            BUSY: begin
               cnt <= cnt + CNT_W'(1);
               if (dmem_ack) begin
                  if (!we_q) begin
                     load_valid <= 1'b1;
                     load_data  <= extract(dmem_rdata, ltype_q, off_q);
                  end
                  state <= DONE;
               end else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                  bus_err <= 1'b1;
                  state   <= DONE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign dmem_req   = (state == BUSY);
   assign dmem_we    = dmem_req & we_q;
   assign dmem_addr  = dmem_req ? addr_q  : 32'h0;
   assign dmem_wstrb = dmem_req ? wstrb_q : 4'b0000;
   assign dmem_wdata = dmem_req ? wdata_q : 32'h0;
   assign stall      = dmem_req | ((state == IDLE) & op);

endmodule

// File: tb/tb_mem_access_controller.sv
// Directed bench for mem_access_controller; expected completions are queued at
// issue time and popped when the controller reaches its DONE cycle.
module tb_mem_access_controller;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_read, mem_write;
   logic [2:0]  mem_load_type;
   logic [1:0]  mem_store_type;
   logic [31:0] addr, store_data;
   logic        dmem_req, dmem_we;
   logic [31:0] dmem_addr, dmem_wdata;
   logic [3:0]  dmem_wstrb;
   logic        dmem_ack;
   logic [31:0] dmem_rdata;
   logic        stall, load_valid, misaligned, bus_err;
   logic [31:0] load_data;

   mem_access_controller #(.TIMEOUT_CYCLES(4), .CNT_W(3)) dut (
      .clk(clk), .rst(rst),
      .mem_read(mem_read), .mem_write(mem_write),
      .mem_load_type(mem_load_type), .mem_store_type(mem_store_type),
      .addr(addr), .store_data(store_data),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
      .dmem_wstrb(dmem_wstrb), .dmem_wdata(dmem_wdata),
      .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
      .stall(stall), .load_valid(load_valid), .load_data(load_data),
      .misaligned(misaligned), .bus_err(bus_err)
   );

   always #5 clk = ~clk;

   // kind: 0 load ok, 1 store ok, 2 misaligned, 3 bus error
   typedef struct { logic [1:0] kind; logic [31:0] data; } exp_t;
   exp_t sb[$];

   int checks = 0;
   int errors = 0;
   logic [31:0] last_load = 32'h0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_op(input string tag, input logic rd, input logic wr,
                         input logic [2:0] lt, input logic [1:0] st,
                         input logic [31:0] a, input logic [31:0] sd,
                         input logic [31:0] rdata, input int ack_at, input int exp_busy,
                         input logic [3:0] ewstrb, input logic [31:0] ewdata,
                         input logic [1:0] kind, input logic [31:0] edata);
      int   busy;
      bit   done;
      exp_t e;
      tick();
      mem_read = rd; mem_write = wr; mem_load_type = lt; mem_store_type = st;
      addr = a; store_data = sd;
      #1;
      check({tag, " idle stall"}, {31'h0, stall}, 32'h1);
      sb.push_back('{kind, (kind == 2'd0) ? edata : last_load});
      busy = 0;
      done = 0;
      for (int n = 0; n < 20 && !done; n++) begin
         tick();
         dmem_ack = 1'b0;
         if (dmem_req) begin
            if (busy == 0) begin
               check({tag, " addr"},  dmem_addr, {a[31:2], 2'b00});
               check({tag, " wstrb"}, {28'h0, dmem_wstrb}, {28'h0, ewstrb});
               check({tag, " wdata"}, dmem_wdata, ewdata);
               check({tag, " we/stall"}, {30'h0, dmem_we, stall}, {30'h0, wr, 1'b1});
            end
            dmem_rdata = rdata;
            dmem_ack   = (busy == ack_at);
            busy++;
         end else begin
            done = 1;
            mem_read = 1'b0; mem_write = 1'b0;
            #1;
            e = sb.pop_front();
            check({tag, " busy cycles"}, busy, exp_busy);
            check({tag, " done flags stall/lv/mis/berr"},
                  {28'h0, stall, load_valid, misaligned, bus_err},
                  {28'h0, 1'b0, e.kind == 2'd0, e.kind == 2'd2, e.kind == 2'd3});
            check({tag, " load_data"}, load_data, e.data);
            if (e.kind == 2'd0) last_load = e.data;
         end
      end
      if (!done) begin
         checks++; errors++;
         $error("FAIL %s: no completion within cycle budget, observed busy %0d expected done", tag, busy);
         mem_read = 1'b0; mem_write = 1'b0; dmem_ack = 1'b0;
      end
   endtask

   initial begin
      rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0; mem_load_type = 3'd0;
      mem_store_type = 2'd0; addr = 32'h0; store_data = 32'h0;
      dmem_ack = 1'b0; dmem_rdata = 32'h0;
      tick(); tick();
      check("reset outputs", {24'h0, dmem_req, dmem_we, dmem_wstrb, stall, load_valid},
            32'h0);
      check("reset addr|wdata|ld|err", dmem_addr | dmem_wdata | load_data |
            {30'h0, misaligned, bus_err}, 32'h0);
      rst = 1'b0;

      run_op("LW",  1, 0, 3'd2, 2'd0, 32'h100, 32'h0, 32'hDEADBEEF, 0, 1, 4'b0000, 32'h0, 2'd0, 32'hDEADBEEF);
      run_op("LB",  1, 0, 3'd0, 2'd0, 32'h103, 32'h0, 32'h80123456, 0, 1, 4'b0000, 32'h0, 2'd0, 32'hFFFFFF80);
      run_op("LBU", 1, 0, 3'd3, 2'd0, 32'h103, 32'h0, 32'h80123456, 2, 3, 4'b0000, 32'h0, 2'd0, 32'h00000080);
      run_op("LH",  1, 0, 3'd1, 2'd0, 32'h102, 32'h0, 32'h80123456, 1, 2, 4'b0000, 32'h0, 2'd0, 32'hFFFF8012);
      run_op("LHU", 1, 0, 3'd4, 2'd0, 32'h102, 32'h0, 32'h80123456, 0, 1, 4'b0000, 32'h0, 2'd0, 32'h00008012);
      run_op("SB",  0, 1, 3'd0, 2'd0, 32'h202, 32'h000000A5, 32'h0, 0, 1, 4'b0100, 32'hA5A5A5A5, 2'd1, 32'h0);
      run_op("SH",  0, 1, 3'd0, 2'd1, 32'h202, 32'h00001234, 32'h0, 1, 2, 4'b1100, 32'h12341234, 2'd1, 32'h0);
      run_op("SW",  0, 1, 3'd0, 2'd2, 32'h204, 32'hCAFEF00D, 32'h0, 0, 1, 4'b1111, 32'hCAFEF00D, 2'd1, 32'h0);
      run_op("SW misaligned", 0, 1, 3'd0, 2'd2, 32'h201, 32'h11111111, 32'h0, 0, 0, 4'b0000, 32'h0, 2'd2, 32'h0);
      run_op("LH misaligned", 1, 0, 3'd1, 2'd0, 32'h101, 32'h0, 32'h0, 0, 0, 4'b0000, 32'h0, 2'd2, 32'h0);
      run_op("rd+wr illegal", 1, 1, 3'd2, 2'd2, 32'h100, 32'h0, 32'h0, 0, 0, 4'b0000, 32'h0, 2'd3, 32'h0);
      run_op("LT=5 illegal",  1, 0, 3'd5, 2'd0, 32'h100, 32'h0, 32'h0, 0, 0, 4'b0000, 32'h0, 2'd3, 32'h0);
      run_op("LW timeout", 1, 0, 3'd2, 2'd0, 32'h140, 32'h0, 32'h55555555, -1, 4, 4'b0000, 32'h0, 2'd3, 32'h0);
      run_op("LW ack on last", 1, 0, 3'd2, 2'd0, 32'h144, 32'h0, 32'h0BADF00D, 3, 4, 4'b0000, 32'h0, 2'd0, 32'h0BADF00D);

      // Stray ack while idle must not produce a load.
      tick();
      dmem_ack = 1'b1; dmem_rdata = 32'hFFFFFFFF;
      tick();
      dmem_ack = 1'b0;
      check("idle ack ignored", {31'h0, load_valid | dmem_req}, 32'h0);
      check("idle ack load_data", load_data, last_load);

      // Reset in the second BUSY cycle, then a late ack.
      tick();
      mem_read = 1'b1; mem_load_type = 3'd2; addr = 32'h300;
      tick();
      check("rst test busy1 req", {31'h0, dmem_req}, 32'h1);
      tick();
      check("rst test busy2 req", {31'h0, dmem_req}, 32'h1);
      rst = 1'b1; mem_read = 1'b0;
      tick();
      check("mid-busy reset outputs",
            {24'h0, dmem_req, dmem_we, dmem_wstrb, stall, load_valid}, 32'h0);
      check("mid-busy reset data", dmem_addr | dmem_wdata | load_data |
            {30'h0, misaligned, bus_err}, 32'h0);
      last_load = 32'h0;
      rst = 1'b0; dmem_ack = 1'b1; dmem_rdata = 32'hAAAAAAAA;
      tick();
      dmem_ack = 1'b0;
      check("late ack ignored", {30'h0, load_valid, dmem_req}, 32'h0);
      check("late ack load_data", load_data, 32'h0);

      run_op("LW after reset", 1, 0, 3'd2, 2'd0, 32'h300, 32'h0, 32'h13579BDF, 0, 1, 4'b0000, 32'h0, 2'd0, 32'h13579BDF);

      check("scoreboard drained", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
